// File: rtl/issue_window_pkg.sv
// Shared types and sizing helpers for the issue_window out-of-order issue buffer.
package issue_window_pkg;

    localparam int IW_DEPTH       = 8;
    localparam int IW_NR_WB_PORTS = 4;
    localparam int IW_TAG_W       = 3;
    localparam int IW_PAYLOAD_W   = 64;
    localparam int IW_OCC_W       = $clog2(IW_DEPTH + 1);

    // Entry layout at the default configuration.
    typedef struct packed {
        logic                    valid;
        logic                    rs1_pend;
        logic [IW_TAG_W-1:0]     rs1_tag;
        logic                    rs2_pend;
        logic [IW_TAG_W-1:0]     rs2_tag;
        logic [IW_PAYLOAD_W-1:0] payload;
    } iw_entry_t;

    function automatic int iw_occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/iw_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
module iw_age_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            ready_i,
    input  logic [DEPTH-1:0][DEPTH-1:0] age_i,
    output logic [DEPTH-1:0]            grant_o,
    output logic                        any_o
);

    logic [DEPTH-1:0] w_blocked;

    always_comb begin
        logic [DEPTH-1:0] w_col;
        w_blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                w_col[j] = age_i[j][i];
            end
            // Self-compare is masked so the diagonal never blocks its own entry.
            w_blocked[i] = |(ready_i & w_col & ~(DEPTH'(1) << i));
        end
    end

    assign grant_o = ready_i & ~w_blocked;
    assign any_o   = |ready_i;

endmodule

// File: rtl/issue_window.sv
// Out-of-order issue window with writeback wakeup and age-matrix oldest-first select.
// Optional macro ISSUE_WINDOW_ENQ_BYPASS_EN adds a 0-cycle enqueue-to-issue path.
module issue_window
    import issue_window_pkg::*;
#(
    parameter int  DEPTH       = IW_DEPTH,
    parameter int  NR_WB_PORTS = IW_NR_WB_PORTS,
    parameter int  TAG_W       = IW_TAG_W,
    parameter int  PAYLOAD_W   = IW_PAYLOAD_W,
    localparam int OCC_W       = iw_occ_width(DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [TAG_W-1:0]             enq_rs1_tag_i,
    input  logic                         enq_rs1_pend_i,
    input  logic [TAG_W-1:0]             enq_rs2_tag_i,
    input  logic                         enq_rs2_pend_i,
    input  logic [PAYLOAD_W-1:0]         enq_payload_i,
    input  logic [NR_WB_PORTS-1:0]       wb_valid_i,
    input  logic [NR_WB_PORTS*TAG_W-1:0] wb_tag_i,
    output logic                         iss_valid_o,
    input  logic                         iss_ready_i,
    output logic [PAYLOAD_W-1:0]         iss_payload_o,
    output logic [OCC_W-1:0]             occupancy_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                 rs1_pend;
        logic [TAG_W-1:0]     rs1_tag;
        logic                 rs2_pend;
        logic [TAG_W-1:0]     rs2_tag;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0]            w_valid_next;
    entry_t                      r_entry [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] r_age;     // r_age[i][j]: entry i older than entry j
    logic [OCC_W-1:0]            r_occ;
    logic [OCC_W-1:0]            w_occ_next;

    logic [DEPTH-1:0]     w_rs1_hit;
    logic [DEPTH-1:0]     w_rs2_hit;
    logic [DEPTH-1:0]     w_ready;
    logic [DEPTH-1:0]     w_grant;
    logic                 w_any_ready;
    logic                 w_enq_rs1_pend;
    logic                 w_enq_rs2_pend;
    logic                 w_free_found;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_enq_fire;
    logic                 w_enq_write;
    logic                 w_res_issue;
    logic                 w_byp_valid;
    logic [PAYLOAD_W-1:0] w_byp_payload;
    logic [PAYLOAD_W-1:0] w_sel_payload;

    function automatic logic tag_hit(
        input logic [NR_WB_PORTS-1:0]       valid,
        input logic [NR_WB_PORTS*TAG_W-1:0] tags,
        input logic [TAG_W-1:0]             tag
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (valid[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_rs1_hit[gi] = tag_hit(wb_valid_i, wb_tag_i, r_entry[gi].rs1_tag);
            assign w_rs2_hit[gi] = tag_hit(wb_valid_i, wb_tag_i, r_entry[gi].rs2_tag);
            // Readiness uses registered pend bits, so a wakeup is visible to select next cycle.
            assign w_ready[gi]   = r_valid[gi] & ~r_entry[gi].rs1_pend & ~r_entry[gi].rs2_pend;
        end
    endgenerate

    iw_age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .ready_i (w_ready),
        .age_i   (r_age),
        .grant_o (w_grant),
        .any_o   (w_any_ready)
    );

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_payload = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_sel_payload = w_sel_payload | r_entry[i].payload;
            end
        end
    end

    assign enq_ready_o    = w_free_found;
    assign w_enq_fire     = enq_valid_i & w_free_found & ~flush_i;
    assign w_enq_rs1_pend = enq_rs1_pend_i & ~tag_hit(wb_valid_i, wb_tag_i, enq_rs1_tag_i);
    assign w_enq_rs2_pend = enq_rs2_pend_i & ~tag_hit(wb_valid_i, wb_tag_i, enq_rs2_tag_i);

`ifdef ISSUE_WINDOW_ENQ_BYPASS_EN
    assign w_byp_valid   = w_enq_fire & ~w_any_ready & ~w_enq_rs1_pend & ~w_enq_rs2_pend;
    assign w_byp_payload = enq_payload_i;
`else
    assign w_byp_valid   = 1'b0;
    assign w_byp_payload = '0;
`endif

    assign iss_valid_o   = (w_any_ready | w_byp_valid) & ~flush_i;
    assign iss_payload_o = !iss_valid_o ? '0 : (w_any_ready ? w_sel_payload : w_byp_payload);
    assign w_res_issue   = iss_valid_o & iss_ready_i & w_any_ready;
    // A bypassed instruction that is accepted immediately never takes a slot.
    assign w_enq_write   = w_enq_fire & ~(w_byp_valid & iss_ready_i);

    always_comb begin
        w_valid_next = r_valid;
        if (flush_i) begin
            w_valid_next = '0;
        end else begin
            if (w_res_issue) begin
                w_valid_next = w_valid_next & ~w_grant;
            end
            if (w_enq_write) begin
                w_valid_next[w_free_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_next = w_occ_next + OCC_W'(w_valid_next[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_age   <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= w_valid_next;
            r_occ   <= w_occ_next;
            if (w_enq_write) begin
                for (int i = 0; i < DEPTH; i++) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (IDX_W'(i) == w_free_idx) begin
                            r_age[i][j] <= 1'b0;
                        end else if (IDX_W'(j) == w_free_idx) begin
                            r_age[i][j] <= r_valid[i];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_enq_write && (IDX_W'(i) == w_free_idx)) begin
                r_entry[i].rs1_pend <= w_enq_rs1_pend;
                r_entry[i].rs1_tag  <= enq_rs1_tag_i;
                r_entry[i].rs2_pend <= w_enq_rs2_pend;
                r_entry[i].rs2_tag  <= enq_rs2_tag_i;
                r_entry[i].payload  <= enq_payload_i;
            end else begin
                r_entry[i].rs1_pend <= r_entry[i].rs1_pend & ~w_rs1_hit[i];
                r_entry[i].rs2_pend <= r_entry[i].rs2_pend & ~w_rs2_hit[i];
            end
        end
    end

    assign occupancy_o = r_occ;

endmodule

// File: tb/tb_issue_window.sv
// Directed vector table plus randomized run against an in-order queue model of the window.
module tb_issue_window;
    import issue_window_pkg::*;

    localparam int DEPTH = 8;
    localparam int NWB   = 4;
    localparam int TW    = 3;
    localparam int PW    = 64;
    localparam int OW    = IW_OCC_W;

`ifdef ISSUE_WINDOW_ENQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    logic [TW-1:0]     r1t = '0;
    logic              r1p = 1'b0;
    logic [TW-1:0]     r2t = '0;
    logic              r2p = 1'b0;
    logic [PW-1:0]     enq_pay = '0;
    logic [NWB-1:0]    wbv = '0;
    logic [NWB*TW-1:0] wbt = '0;
    logic              iss_valid;
    logic              iss_ready = 1'b0;
    logic [PW-1:0]     iss_pay;
    logic [OW-1:0]     occ;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    issue_window #(
        .DEPTH       (DEPTH),
        .NR_WB_PORTS (NWB),
        .TAG_W       (TW),
        .PAYLOAD_W   (PW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .enq_valid_i    (enq_valid),
        .enq_ready_o    (enq_ready),
        .enq_rs1_tag_i  (r1t),
        .enq_rs1_pend_i (r1p),
        .enq_rs2_tag_i  (r2t),
        .enq_rs2_pend_i (r2p),
        .enq_payload_i  (enq_pay),
        .wb_valid_i     (wbv),
        .wb_tag_i       (wbt),
        .iss_valid_o    (iss_valid),
        .iss_ready_i    (iss_ready),
        .iss_payload_o  (iss_pay),
        .occupancy_o    (occ)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        fl, ev, r1p;
        logic [2:0]  r1t;
        logic        r2p;
        logic [2:0]  r2t;
        logic [63:0] pay;
        logic [3:0]  wbv;
        logic [11:0] wbt;
        logic        ir;
        logic        iv;
        logic [63:0] ip;
        logic        er;
        logic [3:0]  occ;
        logic        byp;   // incoming would be presented same-cycle with the bypass path
    } vec_t;

    function automatic vec_t mk(
        input logic fl, input logic ev, input logic r1p_a, input logic [2:0] r1t_a,
        input logic r2p_a, input logic [2:0] r2t_a, input logic [63:0] pay,
        input logic [3:0] wbv_a, input logic [11:0] wbt_a, input logic ir,
        input logic iv, input logic [63:0] ip, input logic er, input logic [3:0] o,
        input logic byp
    );
        vec_t v;
        v = '{fl, ev, r1p_a, r1t_a, r2p_a, r2t_a, pay, wbv_a, wbt_a, ir, iv, ip, er, o, byp};
        return v;
    endfunction

    typedef struct {
        logic        p1;
        logic [2:0]  t1;
        logic        p2;
        logic [2:0]  t2;
        logic [63:0] pay;
    } ment_t;

    ment_t mq[$];

    function automatic logic hit(input logic [3:0] v, input logic [11:0] t, input logic [2:0] tag);
        for (int p = 0; p < NWB; p++) begin
            if (v[p] && (t[p*TW +: TW] == tag)) return 1'b1;
        end
        return 1'b0;
    endfunction

    vec_t tbl[$];

    initial begin
        logic        exp_iv;
        logic [63:0] exp_ip;

        // Hand-derived sequence: ordering, wakeup, hold, full, bypass wakeup, flush.
        tbl.push_back(mk(0,1,0,0,0,0,'hA1,0,0,0,   0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,      1,'hA1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,      0,0,1,0,0));
        tbl.push_back(mk(0,1,1,2,0,0,'hA,0,0,0,    0,0,1,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,'hB,0,0,0,    0,0,1,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,      1,'hB,1,2,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,4'b0010,12'h010,1, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,      1,'hA,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,      0,0,1,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,'hC,0,0,0,    0,0,1,0,1));
        tbl.push_back(mk(0,1,0,0,0,0,'hD,0,0,0,    1,'hC,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,      1,'hC,1,2,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,      1,'hC,1,2,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,      1,'hC,1,2,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,      1,'hD,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,      0,0,1,0,0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(0,1,1,(i == 3) ? 3'd5 : 3'd7,0,0,64'h10 + 64'(i),0,0,0, 0,0,1,4'(i),0));
        end
        tbl.push_back(mk(0,1,0,0,0,0,'hEE,0,0,0,   0,0,0,8,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,4'b0001,12'h005,0, 0,0,0,8,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,      1,'h13,0,8,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,      0,0,1,7,0));
        tbl.push_back(mk(0,1,0,0,1,4,'h44,4'b0001,12'h004,0, 0,0,1,7,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,      1,'h44,0,8,0));
        tbl.push_back(mk(0,1,0,0,0,0,'h55,0,0,0,   0,0,1,7,1));
        tbl.push_back(mk(1,1,0,0,0,0,'h56,0,0,1,   0,0,0,8,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,      0,0,1,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,'h66,0,0,0,   0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,      1,'h66,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,      0,0,1,0,0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_iss_valid", 64'(iss_valid), 64'd0);
        chk("reset_enq_ready", 64'(enq_ready), 64'd1);
        chk("reset_occupancy", 64'(occ), 64'd0);
        chk("reset_payload", iss_pay, 64'd0);

        foreach (tbl[n]) begin
            @(negedge clk);
            flush     = tbl[n].fl;
            enq_valid = tbl[n].ev;
            r1p       = tbl[n].r1p;
            r1t       = tbl[n].r1t;
            r2p       = tbl[n].r2p;
            r2t       = tbl[n].r2t;
            enq_pay   = tbl[n].pay;
            wbv       = tbl[n].wbv;
            wbt       = tbl[n].wbt;
            iss_ready = tbl[n].ir;
            #1;
            exp_iv = tbl[n].iv;
            exp_ip = tbl[n].ip;
            if (BYP && tbl[n].byp) begin
                exp_iv = 1'b1;
                exp_ip = tbl[n].pay;
            end
            chk($sformatf("v%0d_iss_valid", n), 64'(iss_valid), 64'(exp_iv));
            chk($sformatf("v%0d_iss_payload", n), iss_pay, exp_ip);
            chk($sformatf("v%0d_enq_ready", n), 64'(enq_ready), 64'(tbl[n].er));
            chk($sformatf("v%0d_occupancy", n), 64'(occ), 64'(tbl[n].occ));
        end

        // Reset in the middle of operation discards resident entries.
        @(negedge clk);
        flush = 0; wbv = '0; iss_ready = 0;
        enq_valid = 1; r1p = 1; r1t = 3'd6; r2p = 0; enq_pay = 64'h99;
        @(negedge clk);
        r1p = 0; enq_pay = 64'h9A;
        @(negedge clk);
        enq_valid = 0; rst = 1;
        #1;
        chk("midrst_occ_before", 64'(occ), 64'd2);
        chk("midrst_valid_before", 64'(iss_valid), 64'd1);
        @(negedge clk);
        rst = 0;
        #1;
        chk("midrst_occ_after", 64'(occ), 64'd0);
        chk("midrst_valid_after", 64'(iss_valid), 64'd0);
        chk("midrst_ready_after", 64'(enq_ready), 64'd1);

        // Randomized run; model keeps entries in arrival order, so index 0 is the oldest.
        mq.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int          sel;
            logic        e_er, e_iv, fire, byp, in_p1, in_p2;
            logic [63:0] e_ip;
            int          e_occ;
            @(negedge clk);
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            enq_valid = ($urandom_range(0, 9) < 6);
            r1p       = ($urandom_range(0, 2) == 0);
            r1t       = 3'($urandom);
            r2p       = ($urandom_range(0, 2) == 0);
            r2t       = 3'($urandom);
            enq_pay   = {$urandom, $urandom};
            for (int p = 0; p < NWB; p++) wbv[p] = ($urandom_range(0, 3) == 0);
            wbt       = 12'($urandom);
            iss_ready = 1'($urandom_range(0, 1));
            #1;
            sel = -1;
            foreach (mq[i]) begin
                if (sel < 0 && !mq[i].p1 && !mq[i].p2) sel = i;
            end
            e_occ = mq.size();
            e_er  = (mq.size() < DEPTH);
            in_p1 = r1p && !hit(wbv, wbt, r1t);
            in_p2 = r2p && !hit(wbv, wbt, r2t);
            fire  = enq_valid && e_er && !flush;
            byp   = BYP && (sel < 0) && fire && !in_p1 && !in_p2;
            e_iv  = ((sel >= 0) || byp) && !flush;
            e_ip  = !e_iv ? 64'd0 : ((sel >= 0) ? mq[sel].pay : enq_pay);
            chk($sformatf("r%0d_iss_valid", cyc), 64'(iss_valid), 64'(e_iv));
            chk($sformatf("r%0d_iss_payload", cyc), iss_pay, e_ip);
            chk($sformatf("r%0d_enq_ready", cyc), 64'(enq_ready), 64'(e_er));
            chk($sformatf("r%0d_occupancy", cyc), 64'(occ), 64'(e_occ));
            if (rst || flush) begin
                mq.delete();
            end else begin
                if (e_iv && iss_ready && sel >= 0) mq.delete(sel);
                foreach (mq[i]) begin
                    if (hit(wbv, wbt, mq[i].t1)) mq[i].p1 = 1'b0;
                    if (hit(wbv, wbt, mq[i].t2)) mq[i].p2 = 1'b0;
                end
                if (fire && !(byp && iss_ready)) mq.push_back('{in_p1, r1t, in_p2, r2t, enq_pay});
            end
        end

        @(negedge clk);
        rst = 0; flush = 0; enq_valid = 0; wbv = '0; iss_ready = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
